// File: rtl/activation_stream_pkg.sv
// Shared types and constants for the streaming activation unit.
// requant mult and shift are unsigned; add is signed.
package activation_stream_pkg;

    localparam int unsigned N_LANES        = 16;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned GCONST_W       = 16;
    localparam int unsigned RQ_W           = 8;
    localparam int unsigned ACT_STREAM_LAT = 3;
    localparam int unsigned GELU_ACC_W     = 40;
    localparam int unsigned SAT_CNT_W      = 16;
    localparam int unsigned SAT_INC_W      = $clog2(N_LANES + 1);

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        GELU     = 2'd1,
        RELU     = 2'd2
    } activation_e;

    typedef enum logic {
        Signed   = 1'b0,
        Unsigned = 1'b1
    } requant_mode_e;

    typedef struct packed {
        logic signed [GCONST_W-1:0] one;
        logic signed [GCONST_W-1:0] b;
        logic signed [GCONST_W-1:0] c;
        logic        [RQ_W-1:0]     mult;
        logic        [RQ_W-1:0]     shift;
        logic signed [RQ_W-1:0]     add;
        requant_mode_e              requant_mode;
    } gelu_cfg_t;

endpackage

// File: rtl/activation_stream_lane.sv
// One lane of the activation pipeline: S1 clip, S2 polynomial, S3 multiply/requant/clamp.
// All stage registers shift together on en_i.
module activation_stream_lane
    import activation_stream_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  activation_e              act_s2_i,
    input  gelu_cfg_t                cfg_i,
    output logic        [DATA_W-1:0] y_o,
    output logic                     sat_o
);

    localparam int unsigned T_W = GCONST_W + 2;
    localparam int unsigned R_W = GELU_ACC_W + RQ_W;

    logic signed [T_W-1:0]        abs_x, neg_b, clip_v, t_d, t_q;
    logic signed [DATA_W-1:0]     x1_q, x2_q;
    logic signed [GELU_ACC_W-1:0] t_w, poly, e_d, e_q, g;
    logic signed [R_W-1:0]        mult_w, r, lo, hi;
    logic        [DATA_W-1:0]     y_d;
    logic                         sat_d, clamped;

    // S1: |x| is widened first so x = -128 becomes +128 rather than wrapping
    always_comb begin
        abs_x  = x_i[DATA_W-1] ? -T_W'(x_i) : T_W'(x_i);
        neg_b  = -T_W'($signed(cfg_i.b));
        clip_v = (abs_x < neg_b) ? abs_x : neg_b;
        t_d    = clip_v + T_W'($signed(cfg_i.b));
    end

    // S2: erf polynomial with the sign of x folded in
    always_comb begin
        t_w  = GELU_ACC_W'(t_q);
        poly = GELU_ACC_W'($signed(cfg_i.c)) * t_w * t_w + GELU_ACC_W'($signed(cfg_i.one));
        e_d  = x1_q[DATA_W-1] ? -poly : poly;
    end

    // S3: x*(erf+one), round-half-up requant, clamp to the selected output range
    always_comb begin
        g      = GELU_ACC_W'(x2_q) * (e_q + GELU_ACC_W'($signed(cfg_i.one)));
        mult_w = R_W'($signed({1'b0, cfg_i.mult}));
        r      = R_W'(g) * mult_w;
        if (cfg_i.shift != '0) begin
            r = r + (R_W'(1) << (cfg_i.shift - RQ_W'(1)));
        end
        r  = r >>> cfg_i.shift;
        r  = r + R_W'($signed(cfg_i.add));
        lo = (cfg_i.requant_mode == Unsigned) ? R_W'(0)   : R_W'(-128);
        hi = (cfg_i.requant_mode == Unsigned) ? R_W'(255) : R_W'(127);
        clamped = (r < lo) || (r > hi);

        y_d   = x2_q;
        sat_d = 1'b0;
        case (act_s2_i)
            GELU: begin
                if (r < lo) begin
                    y_d = lo[DATA_W-1:0];
                end else if (r > hi) begin
                    y_d = hi[DATA_W-1:0];
                end else begin
                    y_d = r[DATA_W-1:0];
                end
                sat_d = clamped;
            end
            RELU:    y_d = x2_q[DATA_W-1] ? '0 : x2_q;
            default: y_d = x2_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x1_q  <= '0;
            t_q   <= '0;
            x2_q  <= '0;
            e_q   <= '0;
            y_o   <= '0;
            sat_o <= 1'b0;
        end else if (en_i) begin
            x1_q  <= x_i;
            t_q   <= t_d;
            x2_q  <= x1_q;
            e_q   <= e_d;
            y_o   <= y_d;
            sat_o <= sat_d;
        end
    end

endmodule

// File: rtl/activation_stream.sv
// N-lane streaming IDENTITY/RELU/GELU unit with valid/ready flow control and handshaked constants.
// Optional saturation counter: define ACTIVATION_STREAM_SAT_CNT_EN.
module activation_stream
    import activation_stream_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  gelu_cfg_t                   cfg_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [N_LANES*DATA_W-1:0]   in_data_i,
    input  activation_e                 in_act_i,
    input  logic                        in_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [N_LANES*DATA_W-1:0]   out_data_o,
    output logic                        out_last_o,
    output logic [SAT_CNT_W-1:0]        sat_cnt_o
);

    logic [ACT_STREAM_LAT-1:0] vld_q, last_q;
    activation_e               act_s1_q, act_s2_q;
    gelu_cfg_t                 cfg_q;
    logic [N_LANES-1:0]        sat_vec;
    logic                      adv, cfg_fire, in_fire;

    // Constants only change with the pipeline empty, so no beat sees a mix
    assign adv         = !out_valid_o || out_ready_i;
    assign cfg_ready_o = ~|vld_q;
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign in_ready_o  = adv && !cfg_fire;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_valid_o = vld_q[ACT_STREAM_LAT-1];
    assign out_last_o  = last_q[ACT_STREAM_LAT-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q    <= '0;
            last_q   <= '0;
            act_s1_q <= IDENTITY;
            act_s2_q <= IDENTITY;
            cfg_q    <= '0;
        end else begin
            if (cfg_fire) begin
                cfg_q <= cfg_i;
            end
            if (adv) begin
                vld_q    <= {vld_q[ACT_STREAM_LAT-2:0], in_fire};
                last_q   <= {last_q[ACT_STREAM_LAT-2:0], in_fire && in_last_i};
                act_s1_q <= in_act_i;
                act_s2_q <= act_s1_q;
            end
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        activation_stream_lane u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (adv),
            .x_i      (in_data_i[i*DATA_W +: DATA_W]),
            .act_s2_i (act_s2_q),
            .cfg_i    (cfg_q),
            .y_o      (out_data_o[i*DATA_W +: DATA_W]),
            .sat_o    (sat_vec[i])
        );
    end

`ifdef ACTIVATION_STREAM_SAT_CNT_EN
    logic [SAT_INC_W-1:0] sat_inc;
    logic [SAT_CNT_W:0]   sat_sum;

    // Clamped GELU lanes in the beat leaving this cycle, added with saturation
    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sat_inc = sat_inc + SAT_INC_W'(sat_vec[i]);
        end
        sat_sum = {1'b0, sat_cnt_o} + (SAT_CNT_W+1)'(sat_inc);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_o <= '0;
        end else if (cfg_fire) begin
            sat_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i) begin
            sat_cnt_o <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat_vec;
    assign sat_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_activation_stream.sv
// Bench for activation_stream: directed steps plus a randomized phase against a scoreboard model.
module tb_activation_stream;
    import activation_stream_pkg::*;

    localparam int unsigned W = N_LANES * DATA_W;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           sat;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 cfg_valid_i, cfg_ready_o;
    gelu_cfg_t            cfg_i;
    logic                 in_valid_i, in_ready_o;
    logic [W-1:0]         in_data_i;
    activation_e          in_act_i;
    logic                 in_last_i;
    logic                 out_valid_o, out_ready_i;
    logic [W-1:0]         out_data_o;
    logic                 out_last_o;
    logic [SAT_CNT_W-1:0] sat_cnt_o;

    int        n_vec = 0;
    int        n_err = 0;
    exp_t      sb[$];
    gelu_cfg_t mcfg;
    int        m_sat;
    bit        in_fired, cfg_fired;

    always #5 clk_i = ~clk_i;

    activation_stream dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_i       (cfg_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_act_i    (in_act_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .sat_cnt_o   (sat_cnt_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one lane straight from the activation formulas, in 64-bit arithmetic
    function automatic void ref_lane(input int x, input gelu_cfg_t c, input activation_e a,
                                     output logic [7:0] y, output bit s);
        longint ax, nb, qv, t, p, e, g, r;
        s = 1'b0;
        if (a == GELU) begin
            ax = (x < 0) ? -longint'(x) : longint'(x);
            nb = -longint'($signed(c.b));
            qv = (ax < nb) ? ax : nb;
            t  = qv + longint'($signed(c.b));
            p  = longint'($signed(c.c)) * t * t + longint'($signed(c.one));
            e  = (x < 0) ? -p : p;
            g  = longint'(x) * (e + longint'($signed(c.one)));
            r  = g * longint'(c.mult);
            if (c.shift > 0) r = r + (longint'(1) << (c.shift - 1));
            r = r >>> c.shift;
            r = r + longint'($signed(c.add));
            if (c.requant_mode == Unsigned) begin
                if (r < 0) begin y = 8'd0; s = 1'b1; end
                else if (r > 255) begin y = 8'hFF; s = 1'b1; end
                else y = 8'(r);
            end else begin
                if (r < -128) begin y = 8'h80; s = 1'b1; end
                else if (r > 127) begin y = 8'h7F; s = 1'b1; end
                else y = 8'(r);
            end
        end else if (a == RELU) begin
            y = (x < 0) ? 8'd0 : 8'(x);
        end else begin
            y = 8'(x);
        end
    endfunction

    function automatic exp_t model_beat(input logic [W-1:0] d, input activation_e a, input logic l);
        exp_t        e;
        logic [7:0]  y;
        bit          s;
        e.data = '0;
        e.last = l;
        e.sat  = 0;
        for (int i = 0; i < N_LANES; i++) begin
            ref_lane(int'($signed(d[i*DATA_W +: DATA_W])), mcfg, a, y, s);
            e.data[i*DATA_W +: DATA_W] = y;
            e.sat += int'(s);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int i = 0; i < N_LANES; i++) d[i*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    function automatic activation_e rand_act();
        case ($urandom_range(0, 2))
            0:       return IDENTITY;
            1:       return RELU;
            default: return GELU;
        endcase
    endfunction

    function automatic gelu_cfg_t rand_cfg();
        gelu_cfg_t c;
        c.one          = 16'($urandom_range(0, 255));
        c.b            = -16'($urandom_range(1, 64));
        c.c            = 16'($urandom_range(0, 16)) - 16'd8;
        c.mult         = 8'($urandom_range(0, 255));
        c.shift        = 8'($urandom_range(0, 20));
        c.add          = 8'($urandom_range(0, 255));
        c.requant_mode = ($urandom_range(0, 1) == 0) ? Signed : Unsigned;
        return c;
    endfunction

    // One clock: check counter/cfg_ready, score the output handshake, log accepted beats
    task automatic cycle();
        exp_t e;
        int   exp_cnt;
        #1;
`ifdef ACTIVATION_STREAM_SAT_CNT_EN
        exp_cnt = m_sat;
`else
        exp_cnt = 0;
`endif
        check("sat_cnt", 128'(sat_cnt_o), 128'(exp_cnt));
        check("cfg_ready", 128'(cfg_ready_o), 128'(sb.size() == 0));
        in_fired  = in_valid_i && in_ready_o;
        cfg_fired = cfg_valid_i && cfg_ready_o;
        if (cfg_fired) check("cfg_blocks_in", 128'(in_ready_o), 128'(0));
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 128'(out_valid_o), 128'(0));
            end else begin
                e = sb.pop_front();
                check("out_data", out_data_o, e.data);
                check("out_last", 128'(out_last_o), 128'(e.last));
                m_sat = (m_sat + e.sat > 65535) ? 65535 : m_sat + e.sat;
            end
        end
        if (in_fired) sb.push_back(model_beat(in_data_i, in_act_i, in_last_i));
        if (cfg_fired) begin
            mcfg  = cfg_i;
            m_sat = 0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic send(input logic [W-1:0] d, input activation_e a, input logic l);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_act_i   = a;
        in_last_i  = l;
        do begin cycle(); n++; end while (!in_fired && n < 200);
        check("send_accept", 128'(in_fired), 128'(1));
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic load_cfg(input gelu_cfg_t c);
        int n = 0;
        cfg_valid_i = 1'b1;
        cfg_i       = c;
        do begin cycle(); n++; end while (!cfg_fired && n < 50);
        check("cfg_accept", 128'(cfg_fired), 128'(1));
        cfg_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready_i = 1'b1;
        while (sb.size() != 0 && n < 100) begin cycle(); n++; end
        check("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        gelu_cfg_t    base, c2;
        logic [W-1:0] d, held;
        logic         held_last;
        int           xs[6];
        int           waited;

        rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_i = '0; in_valid_i = 1'b0; in_data_i = '0;
        in_act_i = IDENTITY; in_last_i = 1'b0; out_ready_i = 1'b1; mcfg = '0; m_sat = 0;
        base.one = 16'd16; base.b = -16'sd4; base.c = 16'd1; base.mult = 8'd1;
        base.shift = 8'd5; base.add = 8'd0; base.requant_mode = Signed;
        xs = '{0, 4, -4, 127, -1, -128};

        repeat (3) @(negedge clk_i);
        check("rst_out_valid", 128'(out_valid_o), 128'(0));
        check("rst_out_data", out_data_o, 128'(0));
        check("rst_out_last", 128'(out_last_o), 128'(0));
        check("rst_sat_cnt", 128'(sat_cnt_o), 128'(0));
        check("rst_cfg_ready", 128'(cfg_ready_o), 128'(1));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // GELU reference beat, output three cycles after acceptance
        load_cfg(base);
        d = rand_data();
        for (int i = 0; i < 6; i++) d[i*DATA_W +: DATA_W] = 8'(xs[i]);
        send(d, GELU, 1'b1);
        check("lat_c1_valid", 128'(out_valid_o), 128'(0));
        cycle();
        check("lat_c2_valid", 128'(out_valid_o), 128'(0));
        cycle();
        check("lat_c3_valid", 128'(out_valid_o), 128'(1));
        check("gelu_x0",    128'(out_data_o[0*DATA_W +: DATA_W]), 128'(8'h00));
        check("gelu_x4",    128'(out_data_o[1*DATA_W +: DATA_W]), 128'(8'h04));
        check("gelu_xm4",   128'(out_data_o[2*DATA_W +: DATA_W]), 128'(8'h00));
        check("gelu_x127",  128'(out_data_o[3*DATA_W +: DATA_W]), 128'(8'h7F));
        check("gelu_xm1",   128'(out_data_o[4*DATA_W +: DATA_W]), 128'(8'h00));
        check("gelu_xm128", 128'(out_data_o[5*DATA_W +: DATA_W]), 128'(8'h00));
        check("gelu_last",  128'(out_last_o), 128'(1));
        drain();

        // mult=2 clamps the x=127 lane
        c2 = base;
        c2.mult = 8'd2;
        load_cfg(c2);
        send(d, GELU, 1'b0);
        cycle();
        cycle();
        check("clamp_valid", 128'(out_valid_o), 128'(1));
        check("clamp_x127", 128'(out_data_o[3*DATA_W +: DATA_W]), 128'(8'h7F));
        drain();
        cycle();

        // Back-to-back mixed modes on x=-5
        for (int i = 0; i < N_LANES; i++) d[i*DATA_W +: DATA_W] = 8'hFB;
        send(d, IDENTITY, 1'b0);
        send(d, RELU, 1'b0);
        send(d, GELU, 1'b1);
        check("mix_id_valid", 128'(out_valid_o), 128'(1));
        check("mix_id_data", 128'(out_data_o[7:0]), 128'(8'hFB));
        check("mix_id_last", 128'(out_last_o), 128'(0));
        cycle();
        check("mix_relu_data", 128'(out_data_o[7:0]), 128'(8'h00));
        check("mix_relu_last", 128'(out_last_o), 128'(0));
        cycle();
        check("mix_gelu_data", 128'(out_data_o[7:0]), 128'(8'h00));
        check("mix_gelu_last", 128'(out_last_o), 128'(1));
        drain();

        // Downstream stall for 5 cycles
        load_cfg(rand_cfg());
        for (int k = 0; k < 3; k++) send(rand_data(), rand_act(), 1'($urandom_range(0, 1)));
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = rand_data();
        in_act_i    = rand_act();
        in_last_i   = 1'b1;
        #1;
        held      = out_data_o;
        held_last = out_last_o;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_valid", 128'(out_valid_o), 128'(1));
            check("stall_data", out_data_o, held);
            check("stall_last", 128'(out_last_o), 128'(held_last));
            check("stall_in_ready", 128'(in_ready_o), 128'(0));
        end
        out_ready_i = 1'b1;
        cycle();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        drain();

        // Constant update requested with two beats in flight
        send(rand_data(), GELU, 1'b0);
        send(rand_data(), GELU, 1'b0);
        cfg_valid_i = 1'b1;
        cfg_i       = rand_cfg();
        #1;
        check("cfg_busy_ready", 128'(cfg_ready_o), 128'(0));
        waited = 0;
        do begin cycle(); waited++; end while (!cfg_fired && waited < 20);
        cfg_valid_i = 1'b0;
        check("cfg_wait_cycles", 128'(waited), 128'(4));
        send(rand_data(), GELU, 1'b1);
        drain();

        // Config request wins over a simultaneous input beat
        cfg_valid_i = 1'b1;
        cfg_i       = base;
        in_valid_i  = 1'b1;
        in_data_i   = rand_data();
        in_act_i    = GELU;
        #1;
        check("prio_in_ready", 128'(in_ready_o), 128'(0));
        check("prio_cfg_ready", 128'(cfg_ready_o), 128'(1));
        cycle();
        cfg_valid_i = 1'b0;
        cycle();
        in_valid_i = 1'b0;
        drain();

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) send(rand_data(), rand_act(), 1'b1);
        rst_ni = 1'b0;
        #1;
        check("mrst_out_valid", 128'(out_valid_o), 128'(0));
        check("mrst_out_data", out_data_o, 128'(0));
        check("mrst_out_last", 128'(out_last_o), 128'(0));
        check("mrst_sat_cnt", 128'(sat_cnt_o), 128'(0));
        sb.delete();
        mcfg  = '0;
        m_sat = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("mrst_no_stale", 128'(out_valid_o), 128'(0));
        end

        // Randomized traffic with backpressure and occasional constant updates
        load_cfg(rand_cfg());
        for (int it = 0; it < 400; it++) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            if (cfg_valid_i) begin
                in_valid_i = 1'b0;
            end else if (!in_valid_i || in_fired) begin
                in_valid_i = ($urandom_range(0, 3) != 0);
                in_data_i  = rand_data();
                in_act_i   = rand_act();
                in_last_i  = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 39) == 0) begin
                    cfg_valid_i = 1'b1;
                    cfg_i       = rand_cfg();
                    in_valid_i  = 1'b0;
                end
            end
            cycle();
            if (cfg_fired) cfg_valid_i = 1'b0;
        end
        in_valid_i = 1'b0;
        drain();
        cfg_valid_i = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
